// File: rtl/pulse_event_logger.sv
// pulse_event_logger
// Timestamps single-cycle event pulses with a free-running counter and
// queues them in a first-word fall-through FIFO for a downstream consumer.
// A push into a full FIFO without a simultaneous pop is dropped and sets a
// sticky overflow flag; a simultaneous pop frees the slot so nothing drops.
//
// Build option:
//   PULSE_LOGGER_DROP_CNT_EN  adds an 8-bit saturating drop counter output
//                             (drop_cnt). Without it the port and counter
//                             are absent and behaviour is otherwise the same.

module pulse_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pulse_in,
  input  logic                     enable,
  input  logic                     clr_ovf,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W-1:0]          evt_ts,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow
`ifdef PULSE_LOGGER_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);

  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;
  logic            overflow_q, overflow_d;
  logic [TS_W-1:0] mem_q [DEPTH];

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  // Handshake decode: a pop frees the head slot in the same cycle, so a push
  // into a full FIFO is still accepted when the consumer drains concurrently.
  always_comb begin
    push_req = pulse_in & enable;
    pop      = (count_q != '0) & evt_ready;
    full     = (count_q == FULL_CNT);
    push_ok  = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  // Next-state for the timestamp counter, pointers, occupancy and sticky flag.
  always_comb begin
    ts_cnt_d   = ts_cnt_q + TS_ONE;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear must leave the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control state registers; reset discards every stored event at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_cnt_q   <= ts_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are only observable through count_q, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= ts_cnt_q;
    end
  end

  // Fall-through head; forced to zero while empty so reset reads back zero.
  always_comb begin
    evt_valid = (count_q != '0);
    evt_ts    = evt_valid ? mem_q[rd_ptr_q] : '0;
    evt_count = count_q;
    overflow  = overflow_q;
  end

`ifdef PULSE_LOGGER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; a drop outranks a clear in the same cycle.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (clr_ovf) begin
      drop_cnt_d = 8'd0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
